// File: rtl/mult_entry_ctrl_pkg.sv
// Shared constants and state encoding for the multiplier operand-entry sequencer.
package mult_ctrl_pkg;

  localparam int STATE_W     = 3;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [STATE_W-1:0] S_LOAD_A = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD_B = 3'd1;
  localparam logic [STATE_W-1:0] S_START  = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] S_SHOW   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD_A = S_LOAD_A,
    ST_LOAD_B = S_LOAD_B,
    ST_START  = S_START,
    ST_WAIT   = S_WAIT,
    ST_SHOW   = S_SHOW
  } state_e;

endpackage

// File: rtl/mult_entry_ctrl_if.sv
// Operand/start/done handshake between the entry sequencer and the sequential multiplier.
interface mult_entry_ctrl_if
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic               mult_start;
  logic               mult_done;
  logic [2*WIDTH-1:0] mult_product;

  modport master (
    output mult_a,
    output mult_b,
    output mult_start,
    input  mult_done,
    input  mult_product
  );

  modport slave (
    input  mult_a,
    input  mult_b,
    input  mult_start,
    output mult_done,
    output mult_product
  );
endinterface

// File: rtl/mult_entry_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level; history resets high so a
// button held through reset never produces a press.
module btn_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic press
);
  logic prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= level;
  end

  assign press = level & ~prev;
endmodule

// File: rtl/mult_entry_ctrl.sv
// Operand-entry sequencer: captures A then B from switches, starts the multiplier,
// holds the product for display. Optional WAIT timeout under `MULT_TIMEOUT_EN.
module mult_entry_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 btn_next,
  input  logic                 btn_clr,
  input  logic [WIDTH-1:0]     sw,
  mult_entry_ctrl_if.master    mbus,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid,
  output logic                 err,
  output logic [STATE_W-1:0]   state_dbg
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mult_entry_ctrl: TIMEOUT must be at least 2");
  end

  state_e           state, state_nxt;
  logic             press_next, press_clr;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cap_a, cap_b, take_done, take_timeout, leave_show;
  logic             timeout_hit;

  btn_edge u_edge_next (.clock(clock), .reset_n(reset_n), .level(btn_next), .press(press_next));
  btn_edge u_edge_clr  (.clock(clock), .reset_n(reset_n), .level(btn_clr),  .press(press_clr));

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_LOAD_A;
    else          state <= state_nxt;
  end

  // Clear has priority over every other event, including done and timeout.
  always_comb begin
    state_nxt    = state;
    cap_a        = 1'b0;
    cap_b        = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    leave_show   = 1'b0;
    if (press_clr) begin
      state_nxt = ST_LOAD_A;
    end else begin
      case (state)
        ST_LOAD_A: if (press_next) begin
          cap_a     = 1'b1;
          state_nxt = ST_LOAD_B;
        end
        ST_LOAD_B: if (press_next) begin
          cap_b     = 1'b1;
          state_nxt = ST_START;
        end
        ST_START:  state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (mbus.mult_done) begin
            take_done = 1'b1;
            state_nxt = ST_SHOW;
          end else if (timeout_hit) begin
            take_timeout = 1'b1;
            state_nxt    = ST_SHOW;
          end
        end
        ST_SHOW: if (press_next) begin
          leave_show = 1'b1;
          state_nxt  = ST_LOAD_A;
        end
        default:   state_nxt = ST_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q           <= '0;
      b_q           <= '0;
      product       <= '0;
      product_valid <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      err_q         <= 1'b0;
      cnt           <= '0;
`endif
    end else if (press_clr) begin
      a_q           <= '0;
      b_q           <= '0;
      product       <= '0;
      product_valid <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      err_q         <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      if (cap_a) a_q <= sw;
      if (cap_b) b_q <= sw;
      if (take_done) begin
        product       <= mbus.mult_product;
        product_valid <= 1'b1;
      end
      if (leave_show) product_valid <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      if (take_timeout) begin
        err_q         <= 1'b1;
        product       <= '0;
        product_valid <= 1'b0;
      end
      if (leave_show) err_q <= 1'b0;
      // Counter restarts on the START->WAIT transition so each wait gets a full budget.
      if (state == ST_START)     cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + CNT_W'(1);
`else
      if (take_timeout) product_valid <= 1'b0;
`endif
    end
  end

  assign mbus.mult_a     = a_q;
  assign mbus.mult_b     = b_q;
  assign mbus.mult_start = (state == ST_START);
  assign state_dbg       = state;

endmodule
